// File: rtl/tpu_io_pkg.sv
// Shared host-I/O definitions: result frame constants, the streamer state
// encoding used for status readback, and the byte-level framing helpers.
package tpu_io_pkg;

  localparam int         RESULT_DEPTH  = 64;
  localparam int         RESULT_ADDR_W = 6;
  localparam int         RESULT_DATA_W = 16;
  localparam logic [7:0] FRAME_HEADER  = 8'hA5;

  typedef enum logic [2:0] {
    STR_IDLE = 3'd0,
    STR_HDR  = 3'd1,
    STR_WAIT = 3'd2,
    STR_B0   = 3'd3,
    STR_B1   = 3'd4,
    STR_CSUM = 3'd5,
    STR_DONE = 3'd6
  } streamer_state_e;

  // Picks the byte of an FP16 word that goes out first (second = 0) or second.
  function automatic logic [7:0] word_byte(input logic [15:0] word,
                                           input logic        msb_first,
                                           input logic        second);
    word_byte = (msb_first ^ second) ? word[15:8] : word[7:0];
  endfunction

  function automatic logic [7:0] csum_update(input logic [7:0] csum,
                                             input logic [7:0] data);
    csum_update = csum ^ data;
  endfunction

endpackage

// File: rtl/tpu_result_streamer.sv
// Streams the FP16 result memory to the UART TX byte path as a frame:
// header byte, two bytes per word, then an XOR checksum of the data bytes.
module tpu_result_streamer
  import tpu_io_pkg::*;
#(
  parameter int         DEPTH     = RESULT_DEPTH,
  parameter int         ADDR_W    = RESULT_ADDR_W,
  parameter int         DATA_W    = RESULT_DATA_W,
  parameter logic [7:0] HEADER    = FRAME_HEADER,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  streamer_state_e   state_r, state_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              last_r, last_s;
  logic [DATA_W-1:0] word_r, word_s;
  logic [7:0]        csum_r, csum_s;
  logic              tx_valid_r, tx_valid_s;
  logic [7:0]        tx_data_r, tx_data_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              xfer_s;
  logic              rd_en_s;
  logic [7:0]        first_r_s, second_r_s;

  // abort beats a same-cycle handshake: that byte is treated as not sent
  assign xfer_s     = tx_valid_r && tx_ready && !abort;
  assign first_r_s  = word_byte(word_r[15:0], MSB_FIRST, 1'b0);
  assign second_r_s = word_byte(word_r[15:0], MSB_FIRST, 1'b1);

  // Next state, address, word register and checksum.
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    last_s  = last_r;
    word_s  = word_r;
    csum_s  = csum_r;
    rd_en_s = 1'b0;
    if (abort) begin
      state_s = STR_IDLE;
    end else begin
      case (state_r)
        STR_IDLE: begin
          if (start) begin
            state_s = STR_HDR;
            addr_s  = {ADDR_W{1'b0}};
            last_s  = 1'b0;
            csum_s  = 8'h00;
          end else begin
            state_s = STR_IDLE;
          end
        end
        STR_HDR: begin
          // read issued in the accepting cycle so the word is on the bus in WAIT
          if (xfer_s) begin
            rd_en_s = 1'b1;
            state_s = STR_WAIT;
          end else begin
            state_s = STR_HDR;
          end
        end
        STR_WAIT: begin
          word_s  = mem_rd_data;
          state_s = STR_B0;
        end
        STR_B0: begin
          if (xfer_s) begin
            csum_s  = csum_update(csum_r, first_r_s);
            state_s = STR_B1;
            // advance early so the next read address is stable before B1 issues it
            if (addr_r == ADDR_W'(DEPTH - 1)) begin
              last_s = 1'b1;
            end else begin
              addr_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end else begin
            state_s = STR_B0;
          end
        end
        STR_B1: begin
          if (xfer_s) begin
            csum_s = csum_update(csum_r, second_r_s);
            if (last_r) begin
              state_s = STR_CSUM;
            end else begin
              rd_en_s = 1'b1;
              state_s = STR_WAIT;
            end
          end else begin
            state_s = STR_B1;
          end
        end
        STR_CSUM: begin
          if (xfer_s) begin
            state_s = STR_DONE;
          end else begin
            state_s = STR_CSUM;
          end
        end
        STR_DONE: state_s = STR_IDLE;
        default:  state_s = STR_IDLE;
      endcase
    end
  end

  // Output values for the upcoming state, registered below.
  always_comb begin
    tx_valid_s = 1'b0;
    tx_data_s  = 8'h00;
    busy_s     = (state_s != STR_IDLE);
    done_s     = 1'b0;
    case (state_s)
      STR_HDR: begin
        tx_valid_s = 1'b1;
        tx_data_s  = HEADER;
      end
      STR_B0: begin
        tx_valid_s = 1'b1;
        tx_data_s  = word_byte(word_s[15:0], MSB_FIRST, 1'b0);
      end
      STR_B1: begin
        tx_valid_s = 1'b1;
        tx_data_s  = word_byte(word_s[15:0], MSB_FIRST, 1'b1);
      end
      STR_CSUM: begin
        tx_valid_s = 1'b1;
        tx_data_s  = csum_s;
      end
      STR_DONE: done_s = 1'b1;
      default: begin
        tx_valid_s = 1'b0;
        tx_data_s  = 8'h00;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= STR_IDLE;
      addr_r     <= {ADDR_W{1'b0}};
      last_r     <= 1'b0;
      word_r     <= {DATA_W{1'b0}};
      csum_r     <= 8'h00;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      last_r     <= last_s;
      word_r     <= word_s;
      csum_r     <= csum_s;
      tx_valid_r <= tx_valid_s;
      tx_data_r  <= tx_data_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign tx_valid    = tx_valid_r;
  assign tx_data     = tx_data_r;
  assign mem_rd_en   = rd_en_s;
  assign mem_rd_addr = addr_r;

endmodule

// File: tb/tb_tpu_result_streamer.sv
// Scoreboard bench for tpu_result_streamer: expected bytes are queued at
// stimulus time and checked by monitors whenever a TX handshake occurs.
module tb_tpu_result_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0, tx_ready = 1'b1;
  logic        busy, done, mem_rd_en, tx_valid;
  logic [5:0]  mem_rd_addr;
  logic [15:0] mem_rd_data = 16'h0000;
  logic [7:0]  tx_data;

  logic        start2 = 1'b0, abort2 = 1'b0, tx_ready2 = 1'b1;
  logic        busy2, done2, mem_rd_en2, tx_valid2;
  logic [5:0]  mem_rd_addr2;
  logic [15:0] mem_rd_data2 = 16'h0000;
  logic [7:0]  tx_data2;

  logic [15:0] mem [64];
  logic [7:0]  exp_q[$];
  logic [7:0]  exp2_q[$];
  int          n_cmp = 0, n_err = 0;
  int          rd_cnt = 0, done_cnt = 0, sent_cnt = 0, done2_cnt = 0;
  bit          rand_ready = 1'b0;
  bit          hold_pend = 1'b0, abort_prev = 1'b0;
  logic [7:0]  hold_data = 8'h00;

  always #5 clk = ~clk;

  tpu_result_streamer dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  tpu_result_streamer #(.MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .busy(busy2), .done(done2),
    .mem_rd_en(mem_rd_en2), .mem_rd_addr(mem_rd_addr2), .mem_rd_data(mem_rd_data2),
    .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2)
  );

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  always @(posedge clk) if (mem_rd_en2) mem_rd_data2 <= 16'h12AB;

  always @(posedge clk) begin
    #1;
    if (rand_ready) tx_ready = ($urandom_range(0, 9) < 3);
    else            tx_ready = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Main scoreboard monitor: bytes, handshake stability, read addresses, done.
  always @(negedge clk) begin
    if (rst) begin
      hold_pend  = 1'b0;
      abort_prev = 1'b0;
    end else begin
      if (hold_pend && !abort_prev) begin
        check("tx_valid held", 32'(tx_valid), 32'd1);
        check("tx_data held", 32'(tx_data), 32'(hold_data));
      end
      if (tx_valid && tx_ready && !abort) begin
        sent_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra byte: got %0h, expected none", tx_data);
        end else begin
          check("tx byte", 32'(tx_data), 32'(exp_q.pop_front()));
        end
      end
      if (mem_rd_en) begin
        check("rd addr", 32'(mem_rd_addr), 32'(rd_cnt));
        rd_cnt++;
      end
      if (done) done_cnt++;
      hold_pend  = tx_valid && !(tx_ready && !abort);
      hold_data  = tx_data;
      abort_prev = abort;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid2 && tx_ready2) begin
        if (exp2_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra byte lsb: got %0h, expected none", tx_data2);
        end else begin
          check("tx byte lsb", 32'(tx_data2), 32'(exp2_q.pop_front()));
        end
      end
      if (done2) done2_cnt++;
    end
  end

  task automatic push_frame();
    logic [7:0] cs, b0, b1;
    cs = 8'h00;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 64; i++) begin
      b0 = mem[i][15:8];
      b1 = mem[i][7:0];
      exp_q.push_back(b0);
      exp_q.push_back(b1);
      cs = cs ^ b0 ^ b1;
    end
    exp_q.push_back(cs);
  endtask

  // Called at posedge+1; returns at posedge+1 after the edge that samples start.
  task automatic start_frame();
    rd_cnt   = 0;
    done_cnt = 0;
    sent_cnt = 0;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit chk_lat, input int restart_at);
    int lat;
    lat = 0;
    push_frame();
    start_frame();
    while (!done && lat < 3000) begin
      @(posedge clk);
      #1;
      lat++;
      start = (lat == restart_at);
    end
    start = 1'b0;
    if (lat >= 3000) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: got no done after %0d cycles, expected done", tag, lat);
    end else if (chk_lat) begin
      check({tag, " latency"}, 32'(lat), 32'd194);
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, " queue drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, " reads"}, 32'(rd_cnt), 32'd64);
    check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " busy idle"}, 32'(busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    for (int i = 0; i < 64; i++) mem[i] = 16'(16'h0100 * i + i);
    #1 rst = 1'b1;
    #1 check("reset outputs", 32'({busy, done, mem_rd_en, tx_valid, mem_rd_addr, tx_data}), 32'd0);
    check("reset outputs lsb", 32'({busy2, done2, mem_rd_en2, tx_valid2, mem_rd_addr2, tx_data2}), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: incrementing data, ready tied high
    run_frame("incr", 1'b1, 0);

    // 2: same data, ready at ~30% duty
    rand_ready = 1'b1;
    run_frame("rand ready", 1'b0, 0);
    rand_ready = 1'b0;
    @(posedge clk);
    #1;

    // 3: LSB-first instance, all words 12AB
    exp2_q.push_back(8'hA5);
    for (int i = 0; i < 64; i++) begin
      exp2_q.push_back(8'hAB);
      exp2_q.push_back(8'h12);
    end
    exp2_q.push_back(8'h00);
    done2_cnt = 0;
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    lat = 0;
    while (!done2 && lat < 3000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("lsb latency", 32'(lat), 32'd194);
    repeat (3) @(posedge clk);
    #1;
    check("lsb queue drained", 32'(exp2_q.size()), 32'd0);
    check("lsb done pulses", 32'(done2_cnt), 32'd1);
    exp2_q.delete();

    // 4: abort while the 10th data byte is offered with ready high
    push_frame();
    start_frame();
    lat = 0;
    while (!(sent_cnt == 10 && tx_valid) && lat < 500) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("abort reach byte 10", 32'(sent_cnt), 32'd10);
    abort = 1'b1;
    #1 check("abort masks read", 32'(mem_rd_en), 32'd0);
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort drops outputs", 32'({tx_valid, busy, mem_rd_en}), 32'd0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    check("abort no done", 32'(done_cnt), 32'd0);
    check("abort bytes sent", 32'(sent_cnt), 32'd10);
    run_frame("post abort", 1'b1, 0);

    // 5: second start mid-frame is ignored; start+abort while idle does nothing
    run_frame("restart", 1'b1, 50);
    sent_cnt = 0;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("start+abort busy", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("start+abort nothing sent", 32'({tx_valid, busy}), 32'd0);
    check("start+abort byte count", 32'(sent_cnt), 32'd0);

    // 6: async reset between edges while the second byte of word 1 is offered
    push_frame();
    start_frame();
    lat = 0;
    while (!(sent_cnt == 4 && tx_valid) && lat < 500) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("rst reach B1 read", 32'(mem_rd_en), 32'd1);
    #2 rst = 1'b1;
    #1 check("async rst outputs", 32'({busy, done, mem_rd_en, tx_valid, mem_rd_addr, tx_data}), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    run_frame("after rst", 1'b1, 0);

    // 7: irregular data so the checksum is non-trivial
    for (int i = 0; i < 64; i++) mem[i] = 16'(i * 16'h0307) ^ 16'h5A3C;
    run_frame("pattern", 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
